// File: rtl/sram_arbiter.sv
// Two-requester (CPU / debug loader) arbiter for a single-port asynchronous SRAM.
// Round-robin on ties, fixed WAIT_CYCLES strobe width, registered acks and strobes.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    // CPU requester
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    // debug / loader requester
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ack,
    // SRAM side
    output logic [15:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        OE,
    output logic        WE,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_DBG  = 1'b1;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_owner;
    logic        r_last_grant;
    logic        r_we_lat;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_dbg_rdata;
    logic        r_oe;
    logic        r_we;
    logic        r_cpu_ack;
    logic        r_dbg_ack;
    logic        r_busy;

    logic        w_any_req;
    logic        w_grant_dbg;
    logic        w_sel_we;
    logic [15:0] w_sel_addr;
    logic [15:0] w_sel_wdata;

    // Debug wins only when alone, or on a tie when the CPU was served last.
    assign w_any_req   = cpu_req | dbg_req;
    assign w_grant_dbg = dbg_req & (~cpu_req | (r_last_grant == OWN_CPU));
    assign w_sel_we    = w_grant_dbg ? dbg_we    : cpu_we;
    assign w_sel_addr  = w_grant_dbg ? dbg_addr  : cpu_addr;
    assign w_sel_wdata = w_grant_dbg ? dbg_wdata : cpu_wdata;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_DBG;
            r_we_lat     <= 1'b0;
            r_addr       <= 16'h0000;
            r_wdata      <= 16'h0000;
            r_cpu_rdata  <= 16'h0000;
            r_dbg_rdata  <= 16'h0000;
            r_oe         <= 1'b0;
            r_we         <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_dbg_ack    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_grant_dbg;
                        r_last_grant <= w_grant_dbg;
                        r_we_lat     <= w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_cnt        <= 4'd0;
                        r_oe         <= ~w_sel_we;
                        r_we         <= w_sel_we;
                        r_busy       <= 1'b1;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt == LAST_CNT) begin
                        r_oe  <= 1'b0;
                        r_we  <= 1'b0;
                        // Read data is sampled on the edge that closes the strobe window.
                        if (!r_we_lat) begin
                            if (r_owner == OWN_DBG) r_dbg_rdata <= Data_from_SRAM;
                            else                    r_cpu_rdata <= Data_from_SRAM;
                        end
                        r_cpu_ack <= (r_owner == OWN_CPU);
                        r_dbg_ack <= (r_owner == OWN_DBG);
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    r_cpu_ack <= 1'b0;
                    r_dbg_ack <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_oe      <= 1'b0;
                    r_we      <= 1'b0;
                    r_cpu_ack <= 1'b0;
                    r_dbg_ack <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign ADDR         = r_addr;
    assign Data_to_SRAM = r_wdata;
    assign OE           = r_oe;
    assign WE           = r_we;
    assign busy         = r_busy;
    assign cpu_ack      = r_cpu_ack;
    assign dbg_ack      = r_dbg_ack;
    assign cpu_rdata    = r_cpu_rdata;
    assign dbg_rdata    = r_dbg_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: transaction-timeline reference model plus
// directed scenarios (single read/write, ties, late request, reset abort, latency).
module tb_sram_arbiter;
    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [15:0] cpu_rdata, dbg_rdata, ADDR, Data_to_SRAM, Data_from_SRAM;
    logic        cpu_ack, dbg_ack, OE, WE, busy;

    // latency-only instances (WAIT_CYCLES 1 and 15)
    logic        l_req;
    logic [15:0] l1_crd, l1_drd, l1_addr, l1_dts, l15_crd, l15_drd, l15_addr, l15_dts;
    logic        l1_cack, l1_dack, l1_oe, l1_we, l1_busy;
    logic        l15_cack, l15_dack, l15_oe, l15_we, l15_busy;

    always #5 Clk = ~Clk;

    sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .OE(OE), .WE(WE), .busy(busy)
    );

    sram_arbiter #(.WAIT_CYCLES(1)) u_w1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(l_req), .cpu_we(1'b0), .cpu_addr(16'h0040), .cpu_wdata(16'h0000),
        .cpu_rdata(l1_crd), .cpu_ack(l1_cack),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
        .dbg_rdata(l1_drd), .dbg_ack(l1_dack),
        .ADDR(l1_addr), .Data_to_SRAM(l1_dts), .Data_from_SRAM(16'h5A5A),
        .OE(l1_oe), .WE(l1_we), .busy(l1_busy)
    );

    sram_arbiter #(.WAIT_CYCLES(15)) u_w15 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(l_req), .cpu_we(1'b0), .cpu_addr(16'h0040), .cpu_wdata(16'h0000),
        .cpu_rdata(l15_crd), .cpu_ack(l15_cack),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
        .dbg_rdata(l15_drd), .dbg_ack(l15_dack),
        .ADDR(l15_addr), .Data_to_SRAM(l15_dts), .Data_from_SRAM(16'h5A5A),
        .OE(l15_oe), .WE(l15_we), .busy(l15_busy)
    );

    // SRAM device: low 8 address bits, unwritten locations return a seed pattern
    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    logic [15:0] sram [256];
    bit          written [256];

    always_ff @(posedge Clk) begin
        if (WE) begin
            sram[ADDR[7:0]]    <= Data_to_SRAM;
            written[ADDR[7:0]] <= 1'b1;
        end
    end

    always_comb begin
        Data_from_SRAM = 16'h0000;
        if (OE) Data_from_SRAM = written[ADDR[7:0]] ? sram[ADDR[7:0]] : init_val(ADDR[7:0]);
    end

    // checking
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // reference model: each grant at edge g owns cycles g..g+W-1 (strobe), g+W (ack)
    int          cyc;
    int          free_edge;
    bit          last_dbg, t_valid, t_own, t_we, m_dn, auto_on, c_gnt, d_gnt;
    int          t_g;
    logic [15:0] t_addr, t_wdata, t_rd, e_addr, e_wd, e_crd, e_drd;
    logic [15:0] mem [256];
    bit          ack_q[$];
    int          ack_cyc[$];
    int          oe_cnt, we_cnt, cack_cnt, dack_cnt;

    task automatic model_reset();
        t_valid   = 1'b0;
        free_edge = cyc + 1;
        last_dbg  = 1'b1;
        e_addr    = 16'h0;
        e_wd      = 16'h0;
        e_crd     = 16'h0;
        e_drd     = 16'h0;
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        m_dn      = 1'b0;
    endtask

    task automatic model_edge();
        if (cyc >= free_edge && (cpu_req || dbg_req)) begin
            t_own    = dbg_req && (!cpu_req || !last_dbg);
            last_dbg = t_own;
            if (t_own) begin
                t_we = dbg_we; t_addr = dbg_addr; t_wdata = dbg_wdata; d_gnt = 1'b1;
            end else begin
                t_we = cpu_we; t_addr = cpu_addr; t_wdata = cpu_wdata; c_gnt = 1'b1;
            end
            t_rd = mem[t_addr[7:0]];
            if (t_we) mem[t_addr[7:0]] = t_wdata;
            t_g       = cyc;
            t_valid   = 1'b1;
            free_edge = cyc + W + 2;
            e_addr    = t_addr;
            e_wd      = t_wdata;
        end
    endtask

    task automatic model_check();
        bit acc, dn;
        acc  = t_valid && cyc >= t_g && cyc < t_g + W;
        dn   = t_valid && cyc == t_g + W;
        m_dn = dn;
        if (dn && !t_we) begin
            if (t_own) e_drd = t_rd;
            else       e_crd = t_rd;
        end
        chk("OE",        32'(OE),           32'(acc && !t_we));
        chk("WE",        32'(WE),           32'(acc && t_we));
        chk("busy",      32'(busy),         32'(acc || dn));
        chk("cpu_ack",   32'(cpu_ack),      32'(dn && !t_own));
        chk("dbg_ack",   32'(dbg_ack),      32'(dn && t_own));
        chk("ADDR",      32'(ADDR),         32'(e_addr));
        chk("Data_to",   32'(Data_to_SRAM), 32'(e_wd));
        chk("cpu_rdata", 32'(cpu_rdata),    32'(e_crd));
        chk("dbg_rdata", 32'(dbg_rdata),    32'(e_drd));
    endtask

    // requesters: hold until ack, drop next cycle; in auto mode also random traffic
    task automatic drive();
        bit c_was, d_was;
        c_was = cpu_req;
        d_was = dbg_req;
        if (m_dn && !t_own) begin
            c_gnt = 1'b0;
            if (auto_on && $urandom_range(7) == 0) begin
                cpu_we = 1'($urandom_range(1)); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            end else cpu_req = 1'b0;
        end
        if (m_dn && t_own) begin
            d_gnt = 1'b0;
            if (auto_on && $urandom_range(7) == 0) begin
                dbg_we = 1'($urandom_range(1)); dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom);
            end else dbg_req = 1'b0;
        end
        if (auto_on) begin
            if (!c_was && !c_gnt && $urandom_range(2) == 0) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(1));
                cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            end else if (cpu_req && c_gnt) begin
                if ($urandom_range(1) == 1) begin cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom); end
                if ($urandom_range(5) == 0) cpu_req = 1'b0;
            end
            if (!d_was && !d_gnt && $urandom_range(2) == 0) begin
                dbg_req = 1'b1; dbg_we = 1'($urandom_range(1));
                dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom);
            end else if (dbg_req && d_gnt) begin
                if ($urandom_range(1) == 1) begin dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom); end
                if ($urandom_range(5) == 0) dbg_req = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        cyc++;
        model_edge();
        @(negedge Clk);
        model_check();
        oe_cnt   += OE ? 1 : 0;
        we_cnt   += WE ? 1 : 0;
        cack_cnt += cpu_ack ? 1 : 0;
        dack_cnt += dbg_ack ? 1 : 0;
        if (cpu_ack) begin ack_q.push_back(1'b0); ack_cyc.push_back(cyc); end
        if (dbg_ack) begin ack_q.push_back(1'b1); ack_cyc.push_back(cyc); end
        drive();
    endtask

    task automatic clear_stats();
        ack_q.delete(); ack_cyc.delete();
        oe_cnt = 0; we_cnt = 0; cack_cnt = 0; dack_cnt = 0;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k;
        k = 0;
        while (ack_q.size() < n && k < budget) begin step(); k++; end
        chk("ack_wait", 32'(ack_q.size() >= n), 32'd1);
    endtask

    task automatic reset_pulse();
        #1 Reset = 1'b1;
        model_reset();
        #1 model_check();
        #1 Reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, l1_at, l15_at, k;
        Reset = 1'b1; l_req = 1'b0; auto_on = 1'b0; cyc = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
        model_reset();
        repeat (2) @(negedge Clk);
        model_check();
        Reset = 1'b0;

        // single CPU read of the 0xBEEF location
        clear_stats(); c0 = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; cpu_wdata = 16'h1111;
        wait_acks(1, 20); repeat (2) step();
        chk("rd_oe_cycles", 32'(oe_cnt), 32'd2);
        chk("rd_we_cycles", 32'(we_cnt), 32'd0);
        chk("rd_ack_pulses", 32'(cack_cnt), 32'd1);
        chk("rd_latency", 32'(ack_cyc[0] - c0), 32'd3);
        chk("rd_cpu_rdata", 32'(cpu_rdata), 32'h0000BEEF);
        chk("rd_dbg_rdata", 32'(dbg_rdata), 32'd0);

        // single debug write
        clear_stats();
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h1234; dbg_wdata = 16'h00FF;
        wait_acks(1, 20); repeat (2) step();
        chk("wr_we_cycles", 32'(we_cnt), 32'd2);
        chk("wr_oe_cycles", 32'(oe_cnt), 32'd0);
        chk("wr_ack_pulses", 32'(dack_cnt), 32'd1);
        chk("wr_addr_hold", 32'(ADDR), 32'h1234);
        chk("wr_data_hold", 32'(Data_to_SRAM), 32'h00FF);

        // debug request arriving mid CPU access
        clear_stats();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
        step();
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0030;
        wait_acks(2, 40); repeat (2) step();
        chk("late_first", 32'(ack_q[0]), 32'd0);
        chk("late_second", 32'(ack_q[1]), 32'd1);
        chk("late_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'(W + 2));

        // ties right after reset alternate cpu, dbg, cpu, dbg
        reset_pulse();
        clear_stats();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0050;
        wait_acks(2, 40); repeat (2) step();
        cpu_req = 1; dbg_req = 1;
        wait_acks(4, 40); repeat (2) step();
        for (int i = 0; i < 4; i++) chk($sformatf("tie_grant%0d", i), 32'(ack_q[i]), 32'(i % 2));

        // reset in the second access cycle of a CPU read
        clear_stats();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        step(); step();
        #1 Reset = 1'b1; cpu_req = 1'b0;
        #1;
        chk("rst_oe", 32'(OE), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        model_reset();
        model_check();
        #1 Reset = 1'b0;
        repeat (6) step();
        chk("rst_no_ack", 32'(cack_cnt), 32'd0);

        // ack latency for WAIT_CYCLES 1 and 15
        l_req = 1'b1; c0 = cyc; l1_at = 0; l15_at = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (l1_cack && l1_at == 0) l1_at = cyc - c0 + 1;
            if (l15_cack && l15_at == 0) l15_at = cyc - c0 + 1;
        end
        l_req = 1'b0;
        repeat (20) step();
        chk("lat_w1", 32'(l1_at), 32'd3);
        chk("lat_w15", 32'(l15_at), 32'd17);
        chk("w1_rdata", 32'(l1_crd), 32'h5A5A);
        chk("w15_rdata", 32'(l15_crd), 32'h5A5A);
        chk("w1_idle", 32'({l1_busy, l1_oe, l1_we, l1_dack, l1_drd}), 32'd0);
        chk("w15_idle", 32'({l15_busy, l15_oe, l15_we, l15_dack, l15_drd}), 32'd0);
        chk("w1_addr", 32'({l1_addr, l1_dts}), 32'h00400000);
        chk("w15_addr", 32'({l15_addr, l15_dts}), 32'h00400000);

        // random traffic
        clear_stats();
        auto_on = 1'b1;
        repeat (1500) step();
        auto_on = 1'b0;
        k = 0;
        while ((cpu_req || dbg_req || cyc < free_edge) && k < 100) begin step(); k++; end
        chk("drain", 32'(cpu_req || dbg_req || cyc < free_edge), 32'd0);
        chk("rand_traffic", 32'(ack_q.size() > 50), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
